// File: rtl/div_iter.sv
// Iterative RV64M divide/remainder unit (DIV, DIVU, REM, REMU).
// Uses a restoring shift-subtract loop that produces one quotient bit per clock.
// Each trial subtraction goes through a single som_sub instance.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration loop.

module som_sub #(
  parameter int W = 66
) (
  input  logic [W-1:0] i_n1,
  input  logic [W-1:0] i_n2,
  input  logic         i_sub,
  output logic [W-1:0] o_res
);

  // Shared adder/subtractor: i_sub selects i_n1 - i_n2, otherwise i_n1 + i_n2.
  always_comb begin
    o_res = i_sub ? (i_n1 - i_n2) : (i_n1 + i_n2);
  end

endmodule

module div_iter #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         kill,
  input  logic         is_signed,
  input  logic         want_rem,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [N:0]     r_rem;
  logic [N-1:0]   r_quo;
  logic [N-1:0]   r_absB;
  logic [CW-1:0]  r_cnt;
  logic           r_signQ;
  logic           r_signR;
  logic           r_wantRem;
  logic [N-1:0]   r_result;

  logic           w_accept;
  logic           w_fastZero;
  logic [N-1:0]   w_absA;
  logic [N-1:0]   w_absB;
  logic [N:0]     w_shRem;
  logic [N-1:0]   w_shQuo;
  logic [N+1:0]   w_res;
  logic           w_neg;
  logic [N-1:0]   w_quoFix;
  logic [N-1:0]   w_remFix;
  logic           w_bZero;

  assign w_accept = (r_state == IDLE) && start && !kill;

`ifdef DIV_ZERO_FAST_EN
  assign w_fastZero = (divisor == '0);
`else
  assign w_fastZero = 1'b0;
`endif

  // Operand magnitudes; negate only signed operands whose sign bit is set.
  always_comb begin
    w_absA = (is_signed && dividend[N-1]) ? (N'(0) - dividend) : dividend;
    w_absB = (is_signed && divisor[N-1])  ? (N'(0) - divisor)  : divisor;
  end

  // One restoring step: shift {rem, quo} left and trial-subtract the divisor.
  always_comb begin
    w_shRem = {r_rem[N-1:0], r_quo[N-1]};
    w_shQuo = {r_quo[N-2:0], 1'b0};
  end

  som_sub #(.W(N + 2)) u_somSub (
    .i_n1  ({1'b0, w_shRem}),
    .i_n2  ({2'b00, r_absB}),
    .i_sub (1'b1),
    .o_res (w_res)
  );

  assign w_neg = w_res[N+1];

  // Sign correction and divide-by-zero override applied after the loop.
  always_comb begin
    w_bZero  = (r_absB == '0);
    w_quoFix = r_signQ ? (N'(0) - r_quo) : r_quo;
    w_remFix = r_signR ? (N'(0) - r_rem[N-1:0]) : r_rem[N-1:0];
    if (w_bZero) begin
      w_quoFix = '1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus busy/done decode; kill forces IDLE from any state.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = w_fastZero ? FIX : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (r_cnt == CW'(1)) begin
          w_next = FIX;
        end
      end
      FIX: begin
        busy   = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (kill) begin
      w_next = IDLE;
    end
  end

  // Datapath: capture on accept, iterate in CALC, and register the result in FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_absB    <= '0;
      r_cnt     <= '0;
      r_signQ   <= 1'b0;
      r_signR   <= 1'b0;
      r_wantRem <= 1'b0;
      r_result  <= '0;
    end else if (!kill) begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rem     <= w_fastZero ? {1'b0, w_absA} : '0;
            r_quo     <= w_absA;
            r_absB    <= w_absB;
            r_cnt     <= CW'(N);
            r_signQ   <= is_signed && (dividend[N-1] ^ divisor[N-1]);
            r_signR   <= is_signed && dividend[N-1];
            r_wantRem <= want_rem;
          end
        end
        CALC: begin
          r_cnt <= r_cnt - CW'(1);
          if (w_neg) begin
            r_rem <= w_shRem;
            r_quo <= w_shQuo;
          end else begin
            r_rem <= w_res[N:0];
            r_quo <= w_shQuo | N'(1);
          end
        end
        FIX: begin
          r_result <= r_wantRem ? w_remFix : w_quoFix;
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus randomized
// operations checked against a plain-arithmetic reference model.

module tb_div_iter;

  localparam int N = 64;

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         kill;
  logic         is_signed;
  logic         want_rem;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] lastExp = '0;

  div_iter #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .kill      (kill),
    .is_signed (is_signed),
    .want_rem  (want_rem),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [N-1:0] observed, input logic [N-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // RISC-V M-extension division semantics written with plain arithmetic.
  function automatic logic [N-1:0] refDiv(input logic sgn, input logic wr, input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] q;
    logic [N-1:0] r;
    longint       sa;
    longint       sb;
    sa = a;
    sb = b;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sgn && a == {1'b1, {(N-1){1'b0}}} && b == '1) begin
      q = a;
      r = '0;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return wr ? r : q;
  endfunction

  function automatic logic [N-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Drive one request so that it is accepted at the next rising edge (edge 0).
  task automatic launch(input logic sgn, input logic wr, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    start     = 1'b1;
    is_signed = sgn;
    want_rem  = wr;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    is_signed = 1'($urandom);
    want_rem  = 1'($urandom);
    dividend  = rand64();
    divisor   = rand64();
  endtask

  // Full operation: checks done timing, busy span, result and the single-cycle pulse.
  task automatic applyStimulus(input logic sgn, input logic wr, input logic [N-1:0] a, input logic [N-1:0] b,
                               input int pokeEdge, input bit pokeDone, input string tag);
    int           doneEdge = 0;
    int           busyCnt  = 0;
    int           expEdge;
    logic [N-1:0] expRes;
    expRes  = refDiv(sgn, wr, a, b);
    expEdge = (FAST && b == '0) ? 2 : N + 2;
    launch(sgn, wr, a, b);
    for (int k = 1; k <= N + 10; k++) begin
      if (k > 1) @(negedge clk);
      if (done) begin
        doneEdge = k;
        break;
      end
      if (busy) busyCnt++;
      if (k == pokeEdge) begin
        start    = 1'b1;
        dividend = 9;
        divisor  = 3;
      end else begin
        start = 1'b0;
      end
    end
    checkOutput({tag, " doneEdge"}, N'(doneEdge), N'(expEdge));
    checkOutput({tag, " busyCycles"}, N'(busyCnt), N'(expEdge - 1));
    checkOutput({tag, " result"}, result, expRes);
    checkOutput({tag, " busyAtDone"}, N'(busy), N'(0));
    if (pokeDone) begin
      start    = 1'b1;
      dividend = 77;
      divisor  = 7;
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, " donePulse"}, N'(done), N'(0));
    checkOutput({tag, " idleAfter"}, N'(busy), N'(0));
    lastExp = expRes;
  endtask

  // Watch for a number of cycles and report whether done ever rose.
  task automatic watchNoDone(input int cycles, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput({tag, " noDone"}, N'(seen), N'(0));
  endtask

  initial begin
    logic [N-1:0] a;
    logic [N-1:0] b;
    int           sel;
    reset     = 1'b1;
    start     = 1'b0;
    kill      = 1'b0;
    is_signed = 1'b0;
    want_rem  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", N'(busy), N'(0));
    checkOutput("reset done", N'(done), N'(0));
    checkOutput("reset result", result, N'(0));
    reset = 1'b0;

    applyStimulus(1'b0, 1'b0, 64'd100, 64'd7, 0, 1'b0, "divu_100_7");
    applyStimulus(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0, 1'b0, "rem_m100_7");
    applyStimulus(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0, 1'b0, "div_m100_7");
    applyStimulus(1'b1, 1'b0, 64'h8000_0000_0000_0000, '1, 0, 1'b0, "div_ovf");
    applyStimulus(1'b1, 1'b1, 64'h8000_0000_0000_0000, '1, 0, 1'b0, "rem_ovf");
    applyStimulus(1'b0, 1'b0, 64'd5, 64'd0, 0, 1'b0, "divu_5_0");
    applyStimulus(1'b0, 1'b1, 64'd5, 64'd0, 0, 1'b0, "remu_5_0");
    applyStimulus(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 0, 1'b0, "rem_m5_0");
    applyStimulus(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 0, 1'b0, "div_m5_0");
    applyStimulus(1'b0, 1'b0, 64'd50, 64'd5, 10, 1'b1, "divu_50_5_restart");

    // Randomized operations with biased operand classes and stray start pulses.
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 5);
      a   = (sel == 5) ? 64'h8000_0000_0000_0000 : rand64();
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = '1;
        2:       b = N'($urandom_range(1, 15));
        3:       b = {32'h0, $urandom};
        default: b = rand64();
      endcase
      applyStimulus(1'($urandom), 1'($urandom), a, b,
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, N) : 0,
                    1'($urandom), $sformatf("rand%0d", i));
    end

    // Kill mid-iteration: back to IDLE with no done and the old result held.
    launch(1'b0, 1'b0, 64'd1000, 64'd3);
    repeat (18) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    checkOutput("kill busy", N'(busy), N'(0));
    checkOutput("kill done", N'(done), N'(0));
    watchNoDone(N + 5, "kill");
    checkOutput("kill result", result, lastExp);

    // Kill together with start in IDLE: nothing starts.
    @(negedge clk);
    start    = 1'b1;
    kill     = 1'b1;
    dividend = 64'd81;
    divisor  = 64'd9;
    @(negedge clk);
    start = 1'b0;
    kill  = 1'b0;
    checkOutput("killStart busy", N'(busy), N'(0));
    watchNoDone(N + 5, "killStart");
    checkOutput("killStart result", result, lastExp);

    // Reset mid-iteration clears outputs on the next edge.
    launch(1'b1, 1'b0, 64'd12345, 64'd11);
    repeat (28) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midReset busy", N'(busy), N'(0));
    checkOutput("midReset done", N'(done), N'(0));
    checkOutput("midReset result", result, N'(0));
    reset = 1'b0;

    applyStimulus(1'b0, 1'b1, 64'd1001, 64'd10, 0, 1'b0, "afterReset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
